// File: rtl/spi_burst_sequencer.sv
// SPI burst sequencer: measurement-mode command, then repeated read command + RX_BYTES burst + wait.
// Optional per-byte watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_burst_sequencer #(
    parameter int unsigned RX_BYTES       = 6,
    parameter int unsigned INTERVAL       = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  power,
    input  logic                                                  done,
    output logic [1:0]                                            data_select,
    output logic                                                  transfer,
    output logic                                                  receive,
    output logic                                                  cs,
    output logic [((RX_BYTES > 1) ? $clog2(RX_BYTES) : 1)-1:0]    byte_idx,
    output logic                                                  sample_valid,
    output logic                                                  busy,
    output logic                                                  timeout
);

    localparam int unsigned IDX_W = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
    localparam int unsigned CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RX_BYTES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        MEAS,
        CMD,
        RX,
        WAIT,
        SOFT_RST
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic               last_byte;
    logic               xfer_state;
    logic               abort;

    assign last_byte  = (byte_idx == LAST_IDX);
    assign xfer_state = (state == MEAS) || (state == CMD) || (state == RX) || (state == SOFT_RST);

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog;

    // Abort fires on the TIMEOUT_CYCLES-th transfer cycle; a done in that cycle still wins.
    assign abort = xfer_state && !done && (wdog == WDOG_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= abort;
            if (done || (state_next != state)) begin
                wdog <= '0;
            end else if (xfer_state) begin
                wdog <= wdog + 1'b1;
            end
        end
    end
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        idx_next    = byte_idx;
        data_select = 2'b00;
        transfer    = 1'b0;
        receive     = 1'b0;
        cs          = 1'b1;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (power) state_next = MEAS;
            end
            MEAS: begin
                data_select = 2'b01;
                transfer    = !done;
                cs          = done;
                if (done)       state_next = power ? WAIT : SOFT_RST;
                else if (abort) state_next = SOFT_RST;
            end
            CMD: begin
                data_select = 2'b10;
                transfer    = !done;
                cs          = 1'b0;
                if (done)       state_next = power ? RX : SOFT_RST;
                else if (abort) state_next = SOFT_RST;
            end
            RX: begin
                transfer = !done;
                receive  = !done;
                // Chip select stays low across the burst; it rises only as the last byte finishes.
                cs       = done && last_byte;
                if (done) begin
                    if (!power)         state_next = SOFT_RST;
                    else if (last_byte) state_next = WAIT;
                    else                idx_next   = byte_idx + 1'b1;
                end else if (abort) begin
                    state_next = SOFT_RST;
                end
            end
            WAIT: begin
                if (!power)                state_next = SOFT_RST;
                else if (wait_cnt == '0)   state_next = CMD;
            end
            SOFT_RST: begin
                data_select = 2'b11;
                transfer    = !done;
                cs          = done;
                if (done || abort) state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
        if (state_next != RX) idx_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_idx     <= '0;
            wait_cnt     <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_next;
            byte_idx     <= idx_next;
            sample_valid <= (state == RX) && done && last_byte;
            if ((state_next == WAIT) && (state != WAIT)) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer: one 6-byte/10-cycle instance and one 1-byte/1-cycle instance.
// Watchdog scenario runs only when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_burst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       power;
    logic       done;
    logic       sel;

    logic [1:0] a_ds, b_ds;
    logic       a_tr, b_tr, a_rx, b_rx, a_cs, b_cs;
    logic [2:0] a_idx;
    logic [0:0] b_idx;
    logic       a_sv, b_sv, a_busy, b_busy, a_to, b_to;

    logic [1:0] o_ds;
    logic       o_tr, o_rx, o_cs, o_sv, o_busy, o_to;
    logic [2:0] o_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_burst_sequencer #(.RX_BYTES(6), .INTERVAL(10), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .power(power), .done(done),
        .data_select(a_ds), .transfer(a_tr), .receive(a_rx), .cs(a_cs),
        .byte_idx(a_idx), .sample_valid(a_sv), .busy(a_busy), .timeout(a_to)
    );

    spi_burst_sequencer #(.RX_BYTES(1), .INTERVAL(1), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .power(power), .done(done),
        .data_select(b_ds), .transfer(b_tr), .receive(b_rx), .cs(b_cs),
        .byte_idx(b_idx), .sample_valid(b_sv), .busy(b_busy), .timeout(b_to)
    );

    assign o_ds   = sel ? b_ds   : a_ds;
    assign o_tr   = sel ? b_tr   : a_tr;
    assign o_rx   = sel ? b_rx   : a_rx;
    assign o_cs   = sel ? b_cs   : a_cs;
    assign o_idx  = sel ? {2'b00, b_idx} : a_idx;
    assign o_sv   = sel ? b_sv   : a_sv;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_to   = sel ? b_to   : a_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cs"}, o_cs, 1);
        chk({tag, "_transfer"}, o_tr, 0);
        chk({tag, "_receive"}, o_rx, 0);
        chk({tag, "_sel"}, o_ds, 0);
        chk({tag, "_idx"}, o_idx, 0);
        chk({tag, "_sv"}, o_sv, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_timeout"}, o_to, 0);
    endtask

    // Byte of `lat` request cycles followed by a done cycle; power drops at request cycle drop_at.
    task automatic do_byte(input int lat, input logic [1:0] ds, input logic rx, input int idx,
                           input logic cs_end, input int drop_at);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            done = 1'b0;
            if (i == drop_at) power = 1'b0;
            #1;
            chk("xfer_req", o_tr, 1);
            chk("xfer_sel", o_ds, ds);
            chk("xfer_cs", o_cs, 0);
            chk("xfer_receive", o_rx, rx);
            chk("xfer_busy", o_busy, 1);
            if (rx) chk("byte_idx", o_idx, idx);
            if (i == 0) chk("xfer_sv", o_sv, 0);
        end
        @(negedge clk);
        done = 1'b1;
        #1;
        chk("done_xfer", o_tr, 0);
        chk("done_receive", o_rx, 0);
        chk("done_cs", o_cs, cs_end);
        chk("done_sel", o_ds, ds);
    endtask

    task automatic do_wait(input int n, input logic sv_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            done = (i == 1);
            #1;
            chk("wait_cs", o_cs, 1);
            chk("wait_xfer", o_tr, 0);
            chk("wait_busy", o_busy, 1);
            if (i == 0) chk("wait_sv_first", o_sv, sv_first);
            else        chk("wait_sv_low", o_sv, 0);
        end
    endtask

    task automatic burst(input int lat, input int n);
        do_byte(lat, 2'b10, 1'b0, 0, 1'b0, -1);
        for (int k = 0; k < n; k++) begin
            do_byte(lat, 2'b00, 1'b1, k, (k == n - 1), -1);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        done = 1'b0;
        #1;
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_cs"}, o_cs, 1);
        chk({tag, "_xfer"}, o_tr, 0);
        chk({tag, "_sel"}, o_ds, 0);
        chk({tag, "_timeout"}, o_to, 0);
    endtask

    initial begin
        rst   = 1'b1;
        power = 1'b0;
        done  = 1'b0;
        sel   = 1'b0;

        // Instance A: reset, power-up, two full bursts
        @(negedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        idle_check("idle_nopower");
        @(negedge clk);
        power = 1'b1;
        #1;
        chk("power_rise_same_cycle", o_tr, 0);
        do_byte(8, 2'b01, 1'b0, 0, 1'b1, -1);
        do_wait(10, 1'b0);
        burst(8, 6);
        do_wait(10, 1'b1);
        burst(2, 6);

        // Power lost in the third WAIT cycle
        do_wait(2, 1'b1);
        @(negedge clk);
        done  = 1'b0;
        power = 1'b0;
        #1;
        chk("wait3_cs", o_cs, 1);
        chk("wait3_xfer", o_tr, 0);
        do_byte(2, 2'b11, 1'b0, 0, 1'b1, -1);
        idle_check("idle_after_wait_drop");

        // Power lost during RX byte 2
        @(negedge clk);
        power = 1'b1;
        do_byte(2, 2'b01, 1'b0, 0, 1'b1, -1);
        do_wait(10, 1'b0);
        do_byte(2, 2'b10, 1'b0, 0, 1'b0, -1);
        do_byte(2, 2'b00, 1'b1, 0, 1'b0, -1);
        do_byte(2, 2'b00, 1'b1, 1, 1'b0, -1);
        do_byte(3, 2'b00, 1'b1, 2, 1'b0, 1);
        do_byte(2, 2'b11, 1'b0, 0, 1'b1, -1);
        idle_check("idle_after_rx_drop");

        // Asynchronous reset in the middle of CMD
        @(negedge clk);
        power = 1'b1;
        do_byte(2, 2'b01, 1'b0, 0, 1'b1, -1);
        do_wait(10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            done = 1'b0;
            #1;
            chk("cmd_before_rst", o_ds, 2'b10);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_idle", o_tr, 0);
        do_byte(2, 2'b01, 1'b0, 0, 1'b1, -1);

        // Instance B: single-byte bursts with one-cycle WAIT
        sel = 1'b1;
        @(negedge clk);
        done  = 1'b0;
        rst   = 1'b1;
        power = 1'b0;
        #1;
        check_reset_vals("b_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        power = 1'b1;
        #1;
        chk("b_power_rise_same_cycle", o_tr, 0);
        do_byte(3, 2'b01, 1'b0, 0, 1'b1, -1);
        do_wait(1, 1'b0);
        burst(3, 1);
        do_wait(1, 1'b1);
        burst(2, 1);
        do_wait(1, 1'b1);
        burst(2, 1);
        @(negedge clk);
        done  = 1'b0;
        power = 1'b0;
        #1;
        chk("b_wait_sv", o_sv, 1);
        chk("b_wait_cs", o_cs, 1);
        do_byte(2, 2'b11, 1'b0, 0, 1'b1, -1);
        idle_check("b_idle_end");

`ifdef SPI_SEQ_TIMEOUT_EN
        // Watchdog: done withheld in CMD, then again in SOFT_RST
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        power = 1'b1;
        do_byte(2, 2'b01, 1'b0, 0, 1'b1, -1);
        do_wait(10, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            done = 1'b0;
            #1;
            chk("wd_cmd_xfer", o_tr, 1);
            chk("wd_cmd_sel", o_ds, 2'b10);
            chk("wd_cmd_quiet", o_to, 0);
        end
        @(negedge clk);
        power = 1'b0;
        #1;
        chk("wd_pulse_cmd", o_to, 1);
        chk("wd_soft_rst_sel", o_ds, 2'b11);
        chk("wd_soft_rst_xfer", o_tr, 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            chk("wd_srst_xfer", o_tr, 1);
            chk("wd_srst_quiet", o_to, 0);
        end
        @(negedge clk);
        #1;
        chk("wd_pulse_srst", o_to, 1);
        chk("wd_idle_busy", o_busy, 0);
        chk("wd_idle_cs", o_cs, 1);
        @(negedge clk);
        #1;
        chk("wd_pulse_end", o_to, 0);
        chk("wd_stay_idle", o_busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_burst_sequencer.md
# spi_burst_sequencer

Parametrised SPI command sequencer that drives the byte-level SPI transfer engine to stream sensor samples. After power-on it sends a measurement-mode command. It then repeats a fixed cycle: send a read command, read `RX_BYTES` data bytes in one chip-select burst, wait a programmable interval. When power is removed it issues a soft-reset command. It sits between the top-level power switch and the SPI transfer engine, in the same slot as the single-byte command FSM it supersedes.

## Interface
- `RX_BYTES`, 6: data bytes read per burst after the read command; legal range ≥1.
- `INTERVAL`, 1000: clock cycles spent in WAIT between bursts; legal range ≥1.
- `TIMEOUT_CYCLES`, 4096: cycles allowed per byte before abort; used only under `SPI_SEQ_TIMEOUT_EN`.
- One clock; reset is asynchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `power` in 1: power switch, level-sensitive.
- `done` in 1: one-cycle pulse from SPI engine, current byte finished.
- `data_select` out 2: command selector. 00 = dummy, 01 = measurement mode, 10 = read command, 11 = soft reset.
- `transfer` out 1: byte transfer request, held until `done`.
- `receive` out 1: current byte's MISO data is sample data.
- `cs` out 1: chip select, active low.
- `byte_idx` out max(1,$clog2(RX_BYTES)): index of current RX byte, 0-based.
- `sample_valid` out 1: one-cycle pulse, burst of `RX_BYTES` complete.
- `busy` out 1: high in every state except IDLE.
- `timeout` out 1: one-cycle pulse on watchdog abort. Tied 0 without the macro.

## Operation
- States: IDLE, MEAS, CMD, RX, WAIT, SOFT_RST.
- IDLE:
  - Outputs idle.
  - `power`=1 → MEAS.
- MEAS:
  - `data_select`=01, `transfer`=1, `cs`=0.
  - On `done`: → WAIT if `power`=1, else → SOFT_RST.
- CMD:
  - `data_select`=10, `transfer`=1, `cs`=0.
  - On `done`: → RX with `byte_idx`=0 if `power`=1, else → SOFT_RST.
- RX:
  - `data_select`=00, `transfer`=1, `receive`=1, `cs`=0.
  - On `done` with `byte_idx`<RX_BYTES-1: increment `byte_idx`, stay in RX. `cs` stays 0.
  - On `done` with `byte_idx`=RX_BYTES-1: → WAIT and pulse `sample_valid`.
  - On any RX `done` with `power`=0: → SOFT_RST. `sample_valid` is not pulsed unless that byte was the last one.
- WAIT:
  - `cs`=1, no transfer.
  - Interval counter loads `INTERVAL`-1 on entry and decrements each cycle.
  - At 0: → CMD.
  - `power`=0: → SOFT_RST on the next edge, without waiting for the count.
- SOFT_RST:
  - `data_select`=11, `transfer`=1, `cs`=0.
  - On `done`: → IDLE. `power` is ignored here.
- Power loss never truncates a byte in flight. The current byte completes, then the sequencer goes to SOFT_RST.
- In the `done` cycle of any transfer state:
  - `transfer`=0 and `receive`=0.
  - `cs`=1, except in CMD and in non-final RX bytes, where `cs` stays 0.
- `done` outside transfer states (IDLE, WAIT) is ignored.
- Consumer captures MISO byte `byte_idx` when `receive`&`done`.

## Timing
- `rst` asserted, value held until first clock after release:
  - state = IDLE, counters = 0.
  - `cs`=1, `transfer`=0, `receive`=0, `data_select`=00.
  - `byte_idx`=0, `sample_valid`=0, `busy`=0, `timeout`=0.
- `rst` mid-burst: `cs` returns high immediately (asynchronous). No soft-reset command is sent.
- Outputs `data_select`, `transfer`, `receive`, `cs` and `busy` are decoded from state and `done`, combinationally in the same cycle.
- `sample_valid` and `timeout` are registered and high in the first cycle of the destination state.
- `power` rising in IDLE: `transfer`=1 one cycle later.
- Burst period, end of WAIT to next WAIT entry: 1 + sum of per-byte latencies over (1 + `RX_BYTES`) bytes. WAIT lasts exactly `INTERVAL` cycles.
- `RX_BYTES`=1: `byte_idx` is constant 0, and the first RX `done` ends the burst.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined:
  - A per-byte watchdog counter clears on entry to each byte and on every `done`, and increments while `transfer`=1.
  - When it reaches `TIMEOUT_CYCLES`, `timeout` pulses.
  - From MEAS, CMD or RX the sequencer then goes to SOFT_RST. From SOFT_RST it goes to IDLE.
- Not defined: no watchdog logic, `timeout` tied 0, and the sequencer waits for `done` indefinitely.

## Test plan
- `RX_BYTES`=6, `INTERVAL`=10, engine `done` 8 cycles after `transfer` → one 01 byte, then repeated 10 + 6×00 bursts:
  - `byte_idx` steps 0..5 with `cs` low throughout the burst.
  - `sample_valid` pulses once per burst.
  - WAIT is exactly 10 cycles.
- `power` dropped during RX byte 2 → byte 2 completes, `sample_valid` stays low, one 11 byte is sent, then IDLE with `cs`=1.
- `power` dropped in WAIT cycle 3 → SOFT_RST next cycle (`data_select`=11); `done` → IDLE, `busy`=0.
- `rst` asserted mid-CMD → outputs take their reset values asynchronously; after release with `power`=1, the sequence restarts at MEAS.
- `RX_BYTES`=1, `INTERVAL`=1 → each burst is one 10 byte plus one 00 byte, with a 1-cycle WAIT between bursts.
- With `SPI_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `done` withheld in CMD → `timeout` pulses at the 16th transfer cycle, then SOFT_RST. `done` withheld again → `timeout` pulses and the sequencer goes to IDLE.
